// File: rtl/mmio_stream_pkg.sv
// mmio_stream_pkg: register map, control layout and IRQ bits
// shared by the MMIO stream bridge and its FIFO.
package mmio_stream_pkg;

    localparam int IDX_CTRL     = 0;
    localparam int IDX_STATUS   = 1;
    localparam int IDX_IRQ_EN   = 2;
    localparam int IDX_IRQ_STAT = 3;
    localparam int IDX_DATA_I   = 8;
    localparam int IDX_DATA_O   = 16;

    // mode is held at its widest supported size; the top
    // only stores and exposes the low M_WIDTH bits
    typedef struct packed {
        logic [7:0] mode;
        logic       last;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        IRQ_IN_EMPTY  = 2'd0,
        IRQ_OUT_AVAIL = 2'd1,
        IRQ_OVF       = 2'd2,
        IRQ_UDF       = 2'd3
    } irq_bit_e;

    function automatic logic [7:0] sat8(input logic [15:0] n);
        return (n > 16'd255) ? 8'hFF : n[7:0];
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous first-word-fall-through FIFO.
// Head reads 0 while empty; flush clears like reset.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign full_o  = (cnt == (PW+1)'(DEPTH));
    assign empty_o = (cnt == '0);
    assign count_o = cnt;
    assign data_o  = empty_o ? '0 : mem[rptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // storage write; contents are masked by empty_o
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= data_i;
    end

endmodule

// File: rtl/mmio_stream_bridge.sv
// mmio_stream_bridge: MMIO register front-end that packs words
// into wide core beats and unpacks core results into registers.
module mmio_stream_bridge
    import mmio_stream_pkg::*;
#(
    parameter int A_WIDTH  = 8,
    parameter int D_WIDTH  = 32,
    parameter int I_WORDS  = 2,
    parameter int O_WORDS  = 2,
    parameter int IF_DEPTH = 4,
    parameter int OF_DEPTH = 4,
    parameter int M_WIDTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [A_WIDTH-1:0]         wr_addr_i,
    input  logic [D_WIDTH-1:0]         wr_data_i,
    input  logic                       rd_en_i,
    input  logic [A_WIDTH-1:0]         rd_addr_i,
    output logic [D_WIDTH-1:0]         rd_data_o,
    output logic                       irq_o,
    output logic                       core_rst_o,
    output logic [M_WIDTH-1:0]         core_mode_o,
    output logic                       core_last_o,
    output logic [I_WORDS*D_WIDTH-1:0] core_data_o,
    output logic                       core_valid_o,
    input  logic                       core_ready_i,
    input  logic [O_WORDS*D_WIDTH-1:0] res_data_i,
    input  logic                       res_valid_i,
    output logic                       res_ready_o
);

    localparam int IW  = A_WIDTH - 2;
    localparam int IBW = I_WORDS * D_WIDTH;
    localparam int OBW = O_WORDS * D_WIDTH;
    localparam int ICW = $clog2(IF_DEPTH) + 1;
    localparam int OCW = $clog2(OF_DEPTH) + 1;

    localparam logic [IW-1:0] W_CTRL  = IW'(IDX_CTRL);
    localparam logic [IW-1:0] W_STAT  = IW'(IDX_STATUS);
    localparam logic [IW-1:0] W_IEN   = IW'(IDX_IRQ_EN);
    localparam logic [IW-1:0] W_IST   = IW'(IDX_IRQ_STAT);
    localparam logic [IW-1:0] W_DI_LS = IW'(IDX_DATA_I + I_WORDS - 1);
    localparam logic [IW-1:0] W_DO_LS = IW'(IDX_DATA_O + O_WORDS - 1);

    logic [IW-1:0]      wr_idx;
    logic [IW-1:0]      rd_idx;
    ctrl_t              ctrl_q;
    logic [3:0]         irq_en_q;
    logic [3:0]         irq_stat_q;
    logic [3:0]         irq_set;
    logic [3:0]         irq_clr;
    logic [D_WIDTH-1:0] stage_q [I_WORDS];
    logic [IBW-1:0]     in_beat;
    logic [IBW:0]       in_head;
    logic               in_push;
    logic               in_pop;
    logic               in_full;
    logic               in_empty;
    logic [ICW-1:0]     in_cnt;
    logic [OBW-1:0]     out_head;
    logic               out_push;
    logic               out_pop;
    logic               out_full;
    logic               out_empty;
    logic [OCW-1:0]     out_cnt;
    logic               flush;
    logic               rd_last;
    logic [D_WIDTH-1:0] rd_val;
    logic [D_WIDTH-1:0] do_word;
    logic               unused_bits;

    assign wr_idx      = wr_addr_i[A_WIDTH-1:2];
    assign rd_idx      = rd_addr_i[A_WIDTH-1:2];
    assign unused_bits = ^{wr_addr_i[1:0], rd_addr_i[1:0],
                           ctrl_q.mode};

    assign flush    = ~ctrl_q.en;
    assign in_push  = wr_en_i & (wr_idx == W_DI_LS);
    assign in_pop   = core_valid_o & core_ready_i;
    assign out_push = res_valid_i & res_ready_o;
    assign rd_last  = rd_en_i & (rd_idx == W_DO_LS);
    assign out_pop  = rd_last & ~out_empty;

    assign core_valid_o = ~in_empty;
    assign core_last_o  = in_head[IBW];
    assign core_data_o  = in_head[IBW-1:0];
    assign res_ready_o  = ~out_full;
    assign core_rst_o   = rst_i | flush;
    assign core_mode_o  = ctrl_q.mode[M_WIDTH-1:0];
    assign irq_o        = |(irq_stat_q & irq_en_q);

    // beat being pushed: staged words plus the word on the bus
    always_comb begin
        in_beat = '0;
        for (int k = 0; k < I_WORDS; k++) begin
            in_beat[k*D_WIDTH +: D_WIDTH] =
                (k == I_WORDS - 1) ? wr_data_i : stage_q[k];
        end
    end

    // staging words, cleared while the core is disabled
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            for (int k = 0; k < I_WORDS; k++) stage_q[k] <= '0;
        end else if (wr_en_i) begin
            for (int k = 0; k < I_WORDS; k++) begin
                if (wr_idx == IW'(IDX_DATA_I + k))
                    stage_q[k] <= wr_data_i;
            end
        end
    end

    // interrupt set events and W1C mask; flush raises no edges
    always_comb begin
        irq_set = '0;
        irq_set[IRQ_IN_EMPTY]  = in_pop & ~in_push & ctrl_q.en
                               & (in_cnt == ICW'(1));
        irq_set[IRQ_OUT_AVAIL] = out_push & out_empty & ctrl_q.en;
        irq_set[IRQ_OVF]       = in_push & in_full & ~in_pop;
        irq_set[IRQ_UDF]       = rd_last & out_empty;
        irq_clr = '0;
        if (wr_en_i && wr_idx == W_IST) irq_clr = wr_data_i[3:0];
    end

    // control and interrupt registers; set beats clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
        end else begin
            if (wr_en_i && wr_idx == W_CTRL) begin
                ctrl_q.en   <= wr_data_i[0];
                ctrl_q.last <= wr_data_i[1];
                ctrl_q.mode <= 8'(wr_data_i[2 +: M_WIDTH]);
            end
            if (wr_en_i && wr_idx == W_IEN)
                irq_en_q <= wr_data_i[3:0];
            irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_set;
        end
    end

    // selected word of the output head
    always_comb begin
        do_word = '0;
        for (int k = 0; k < O_WORDS; k++) begin
            if (rd_idx == IW'(IDX_DATA_O + k))
                do_word = out_head[k*D_WIDTH +: D_WIDTH];
        end
    end

    // register read mux
    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            (rd_idx == W_CTRL): begin
                rd_val[0]           = ctrl_q.en;
                rd_val[1]           = ctrl_q.last;
                rd_val[2 +: M_WIDTH] = ctrl_q.mode[M_WIDTH-1:0];
            end
            (rd_idx == W_STAT): begin
                rd_val[7:0]  = sat8(16'(in_cnt));
                rd_val[15:8] = sat8(16'(out_cnt));
                rd_val[16]   = in_full;
                rd_val[17]   = out_empty;
            end
            (rd_idx == W_IEN): rd_val[3:0] = irq_en_q;
            (rd_idx == W_IST): rd_val[3:0] = irq_stat_q;
            default:           rd_val = do_word;
        endcase
    end

    // registered read data, held between reads
    always_ff @(posedge clk_i) begin
        if (rst_i)        rd_data_o <= '0;
        else if (rd_en_i) rd_data_o <= rd_val;
    end

    stream_fifo #(
        .WIDTH (IBW + 1),
        .DEPTH (IF_DEPTH)
    ) u_in_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .push_i  (in_push),
        .pop_i   (in_pop),
        .data_i  ({ctrl_q.last, in_beat}),
        .data_o  (in_head),
        .full_o  (in_full),
        .empty_o (in_empty),
        .count_o (in_cnt)
    );

    stream_fifo #(
        .WIDTH (OBW),
        .DEPTH (OF_DEPTH)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush),
        .push_i  (out_push),
        .pop_i   (out_pop),
        .data_i  (res_data_i),
        .data_o  (out_head),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_cnt)
    );

endmodule

// File: tb/tb_mmio_stream_bridge.sv
// tb_mmio_stream_bridge: directed register-map scenarios followed
// by random traffic, compared against a queue-level model.
module tb_mmio_stream_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        irq;
    logic        core_rst;
    logic [1:0]  core_mode;
    logic        core_last;
    logic [63:0] core_data;
    logic        core_valid;
    logic        core_ready;
    logic [63:0] res_data;
    logic        res_valid;
    logic        res_ready;

    always #5 clk = ~clk;

    mmio_stream_bridge dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .rd_en_i      (rd_en),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .irq_o        (irq),
        .core_rst_o   (core_rst),
        .core_mode_o  (core_mode),
        .core_last_o  (core_last),
        .core_data_o  (core_data),
        .core_valid_o (core_valid),
        .core_ready_i (core_ready),
        .res_data_i   (res_data),
        .res_valid_i  (res_valid),
        .res_ready_o  (res_ready)
    );

    // reference state
    bit [64:0] in_q[$];
    bit [63:0] out_q[$];
    bit        m_en;
    bit        m_last;
    bit [1:0]  m_mode;
    bit [3:0]  m_ien;
    bit [3:0]  m_ist;
    bit [31:0] m_stage[2];
    bit [31:0] m_rd;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] v;
    logic [31:0] s0;

    task automatic check(input string tag,
                         input logic [64:0] got,
                         input logic [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input int idx);
        case (idx)
            0:  return {28'b0, m_mode, m_last, m_en};
            1:  return {14'b0, out_q.size() == 0,
                        in_q.size() == 4,
                        8'(out_q.size()), 8'(in_q.size())};
            2:  return {28'b0, m_ien};
            3:  return {28'b0, m_ist};
            16: return out_q.size() ? out_q[0][31:0] : 32'h0;
            17: return out_q.size() ? out_q[0][63:32] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // one clock of the bridge, from the rules on queues
    task automatic model_step();
        bit        in_pop, out_pop, res_push, push, drop;
        bit [3:0]  set, w1c;
        bit [64:0] beat;
        int        wi, ri;
        if (rst) begin
            in_q.delete();
            out_q.delete();
            m_en = 0; m_last = 0; m_mode = 0;
            m_ien = 0; m_ist = 0; m_rd = 0;
            m_stage[0] = 0; m_stage[1] = 0;
            return;
        end
        wi       = int'(wr_addr[7:2]);
        ri       = int'(rd_addr[7:2]);
        set      = 0;
        w1c      = 0;
        out_pop  = 0;
        in_pop   = in_q.size() > 0 && core_ready;
        res_push = res_valid && out_q.size() < 4;
        if (rd_en) begin
            m_rd = m_read(ri);
            if (ri == 17) begin
                if (out_q.size() == 0) set[3] = 1;
                else out_pop = 1;
            end
        end
        if (wr_en && wi == 3) w1c = wr_data[3:0];
        push = wr_en && wi == 9;
        beat = {m_last, wr_data, m_stage[0]};
        drop = push && in_q.size() == 4 && !in_pop;
        if (drop) set[2] = 1;
        if (in_pop && !push && in_q.size() == 1 && m_en)
            set[0] = 1;
        if (res_push && out_q.size() == 0 && m_en) set[1] = 1;
        if (wr_en && wi == 8) m_stage[0] = wr_data;
        if (wr_en && wi == 9) m_stage[1] = wr_data;
        if (in_pop) void'(in_q.pop_front());
        if (push && !drop) in_q.push_back(beat);
        if (out_pop) void'(out_q.pop_front());
        if (res_push) out_q.push_back(res_data);
        if (!m_en) begin
            in_q.delete();
            out_q.delete();
            m_stage[0] = 0;
            m_stage[1] = 0;
        end
        if (wr_en && wi == 0) begin
            m_en   = wr_data[0];
            m_last = wr_data[1];
            m_mode = wr_data[3:2];
        end
        if (wr_en && wi == 2) m_ien = wr_data[3:0];
        m_ist = (m_ist & ~w1c) | set;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("rd_data", rd_data, m_rd);
        check("core_valid", core_valid, in_q.size() != 0);
        if (in_q.size() != 0) begin
            check("core_data", core_data, in_q[0][63:0]);
            check("core_last", core_last, in_q[0][64]);
        end
        check("irq", irq, |(m_ist & m_ien));
        check("core_rst", core_rst, rst | !m_en);
        check("core_mode", core_mode, m_mode);
        check("res_ready", res_ready, out_q.size() != 4);
    endtask

    task automatic wr(input int idx, input bit [31:0] d);
        wr_en   = 1;
        wr_addr = {6'(idx), 2'($urandom)};
        wr_data = d;
        step();
        wr_en = 0;
    endtask

    task automatic rd(input int idx, output logic [31:0] r);
        rd_en   = 1;
        rd_addr = {6'(idx), 2'($urandom)};
        step();
        rd_en = 0;
        r = rd_data;
    endtask

    task automatic res_beat(input bit [63:0] d);
        res_valid = 1;
        res_data  = d;
        step();
        res_valid = 0;
    endtask

    int pick[11] = '{0, 1, 2, 3, 8, 9, 9, 16, 17, 5, 20};

    initial begin
        rst = 1; wr_en = 0; rd_en = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0;
        core_ready = 0; res_valid = 0; res_data = 0;
        step();
        step();
        check("rst_rd_data", rd_data, 0);
        check("rst_irq", irq, 0);
        check("rst_core_rst", core_rst, 1);
        check("rst_valid", core_valid, 0);
        check("rst_res_ready", res_ready, 1);
        rst = 0;
        step();

        // first beat
        wr(0, 32'h1);
        wr(8, 32'h11111111);
        wr(9, 32'h22222222);
        check("t1_valid", core_valid, 1);
        check("t1_data", core_data, 64'h22222222_11111111);
        check("t1_last", core_last, 0);

        // overflow with a stalled core
        for (int i = 0; i < 4; i++) begin
            wr(8, $urandom);
            wr(9, $urandom);
        end
        rd(1, v);
        check("t2_status", v, 32'h0003_0004);
        rd(3, v);
        check("t2_ovf", v, 32'h4);
        wr(2, 32'h4);
        check("t2_irq_on", irq, 1);
        wr(3, 32'h4);
        check("t2_irq_off", irq, 0);

        // drain, then one core result
        core_ready = 1;
        repeat (4) step();
        core_ready = 0;
        res_beat(64'hAAAABBBB_CCCCDDDD);
        rd(3, v);
        check("t3_avail", v[1], 1);
        rd(16, v);
        check("t3_do0", v, 32'hCCCCDDDD);
        rd(17, v);
        check("t3_do1", v, 32'hAAAABBBB);
        rd(1, v);
        check("t3_out_empty", v[17], 1);

        // underflow
        rd(17, v);
        check("t4_udf_data", v, 0);
        rd(3, v);
        check("t4_udf", v[3], 1);
        rd(1, v);
        check("t4_out_cnt", v[15:8], 0);

        // disable flushes queued beats, keeps IRQ state
        wr(8, 32'h01020304);
        wr(9, 32'h05060708);
        wr(8, 32'h090A0B0C);
        wr(9, 32'h0D0E0F10);
        res_beat(64'h1234_5678_9ABC_DEF0);
        wr(2, 32'hB);
        rd(3, s0);
        wr(0, 32'h0);
        check("t5_core_rst", core_rst, 1);
        step();
        rd(1, v);
        check("t5_cnts", v[15:0], 0);
        rd(2, v);
        check("t5_ien", v, 32'hB);
        rd(3, v);
        check("t5_ist", v, s0);
        wr(0, 32'h1);

        // reset in the middle of traffic
        wr(8, 32'hDEADBEEF);
        wr(9, 32'hCAFEF00D);
        res_beat(64'h5555_6666_7777_8888);
        rst = 1;
        step();
        check("t6_valid", core_valid, 0);
        check("t6_core_rst", core_rst, 1);
        check("t6_res_ready", res_ready, 1);
        check("t6_irq", irq, 0);
        check("t6_rd_data", rd_data, 0);
        rst = 0;
        wr(0, 32'h1);
        repeat (3) begin
            step();
            check("t6_no_stale", core_valid, 0);
        end

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            core_ready = ($urandom_range(0, 2) == 0);
            res_valid  = ($urandom_range(0, 2) == 0);
            res_data   = {$urandom, $urandom};
            wr_en      = $urandom_range(0, 1);
            wr_addr    = {6'(pick[$urandom_range(0, 10)]),
                          2'($urandom)};
            wr_data    = $urandom;
            if (wr_addr[7:2] == 0)
                wr_data[0] = ($urandom_range(0, 9) != 0);
            rd_en      = $urandom_range(0, 1);
            rd_addr    = {6'(pick[$urandom_range(0, 10)]),
                          2'($urandom)};
            step();
        end
        rst = 0; wr_en = 0; rd_en = 0; res_valid = 0;
        step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
